crc_checker: RTL and testbench

//  Receive-side counterpart of the serial CRC generator: recomputes the CRC over a serial data

---
 rtl/crc_pkg.sv | 30 +++
 rtl/crc_lfsr_core.sv | 45 ++++
 rtl/crc_checker.sv | 154 +++++++++++++++
 tb/tb_crc_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared constants, FSM state type and LFSR step function
// for the serial CRC checker and its generator counterpart.
package crc_pkg;

  localparam int unsigned CRC_N     = 8;
  localparam logic [7:0]  CRC_SEED  = 8'hD8;
  localparam logic [7:0]  CRC_TAPS  = 8'h44;
  localparam int unsigned CRC_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // One data-bit step: feedback enters the MSB and is XORed
  // into every lower bit whose tap is set.
  function automatic logic [CRC_N-1:0] lfsr_next(
    input logic [CRC_N-1:0] r,
    input logic             d,
    input logic [CRC_N-1:0] taps
  );
    logic             fb;
    logic [CRC_N-1:0] m;
    fb = d ^ r[0];
    m  = {1'b0, taps[CRC_N-2:0]};
    return {fb, r[CRC_N-1:1]} ^ ({CRC_N{fb}} & m);
  endfunction

endpackage

// File: rtl/crc_lfsr_core.sv
// CRC LFSR: optional SEED reload, then data update or compare-shift.
// Ports: clk_i, rst_i, load_i, upd_i, cmp_i, data_i in; bit_o = LSB under test.
module crc_lfsr_core
  import crc_pkg::*;
#(
  parameter int unsigned N    = CRC_N,
  parameter logic [N-1:0] SEED = CRC_SEED,
  parameter logic [N-1:0] TAPS = CRC_TAPS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic upd_i,
  input  logic cmp_i,
  input  logic data_i,
  output logic bit_o
);

  logic [N-1:0] lfsr_q;
  logic [N-1:0] lfsr_d;
  logic [N-1:0] base;

  // load_i makes this cycle's operation act on SEED instead of
  // the stored value, so a frame start costs no extra cycle.
  assign base  = load_i ? SEED : lfsr_q;
  assign bit_o = base[0];

  always_comb begin
    lfsr_d = base;
    if (upd_i) begin
      lfsr_d = lfsr_next(base, data_i, TAPS);
    end else if (cmp_i) begin
      lfsr_d = base >> 1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/crc_checker.sv
// Serial CRC checker: recomputes CRC over data phase, checks CRC phase.
// Ports: Clk, Rst, Data, Active, Crc_Valid, Clr_Cnt in; Busy, Done, Pass, Frame_Err, Err_Count out.
module crc_checker
  import crc_pkg::*;
#(
  parameter int unsigned  N     = CRC_N,
  parameter logic [N-1:0] SEED  = CRC_SEED,
  parameter logic [N-1:0] TAPS  = CRC_TAPS,
  parameter int unsigned  CNT_W = CRC_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Data,
  input  logic             Active,
  input  logic             Crc_Valid,
  input  logic             Clr_Cnt,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic             Frame_Err,
  output logic [CNT_W-1:0] Err_Count
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             ferr_q, ferr_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic          start;
  logic          take;
  logic          load;
  logic          ref_bit;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_step;
  logic          mis_base;
  logic          mis_step;
  logic          last;

  // Active outranks Crc_Valid in every state.
  assign start = Active;
  assign take  = ~Active & Crc_Valid;

  // SEED is the operand whenever a frame begins: from IDLE
  // (data or zero-length frame) or on a restart out of CHECK.
  assign load = (state_q == ST_IDLE) |
                ((state_q == ST_CHECK) & Active);

  crc_lfsr_core #(
    .N    (N),
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .load_i (load),
    .upd_i  (start),
    .cmp_i  (take),
    .data_i (Data),
    .bit_o  (ref_bit)
  );

  // A CRC bit arriving outside CHECK is the first one of the frame.
  assign cnt_base = (state_q == ST_CHECK) ? cnt_q : '0;
  assign mis_base = (state_q == ST_IDLE) ? 1'b0 : mis_q;
  assign cnt_step = cnt_base + 1'b1;
  assign mis_step = mis_base | (Data ^ ref_bit);
  assign last     = (cnt_step == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    ferr_d  = ferr_q;
    unique case (1'b1)
      start: begin
        if (state_q == ST_CHECK) begin
          done_d = 1'b1;
          pass_d = 1'b0;
          ferr_d = 1'b1;
        end
        state_d = ST_DATA;
        cnt_d   = '0;
        mis_d   = 1'b0;
      end
      take: begin
        state_d = ST_CHECK;
        cnt_d   = cnt_step;
        mis_d   = mis_step;
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          pass_d  = ~mis_step;
          ferr_d  = 1'b0;
        end
      end
      default: begin
        // Idle line during CHECK means the CRC phase ended short.
        if (state_q == ST_CHECK) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          ferr_d  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (Clr_Cnt) begin
      err_d = '0;
    end else if (done_d & ~pass_d & (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ferr_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ferr_q  <= ferr_d;
      err_q   <= err_d;
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = done_q;
  assign Pass      = pass_q;
  assign Frame_Err = ferr_q;
  assign Err_Count = err_q;

endmodule

// File: tb/tb_crc_checker.sv
// Directed + randomized bench for crc_checker against a
// frame-level CRC model.
module tb_crc_checker;

  logic       Clk;
  logic       Rst;
  logic       Data;
  logic       Active;
  logic       Crc_Valid;
  logic       Clr_Cnt;
  logic       Busy;
  logic       Done;
  logic       Pass;
  logic       Frame_Err;
  logic [7:0] Err_Count;

  int n_assert;
  int n_fail;
  int exp_err;

  crc_checker dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Data      (Data),
    .Active    (Active),
    .Crc_Valid (Crc_Valid),
    .Clr_Cnt   (Clr_Cnt),
    .Busy      (Busy),
    .Done      (Done),
    .Pass      (Pass),
    .Frame_Err (Frame_Err),
    .Err_Count (Err_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // CRC of a frame: start from 0xD8, per bit shift right, and
  // when (bit xor LSB) is 1 XOR in 0x80 (new MSB) | 0x44 (taps).
  function automatic logic [7:0] model_crc(input int nd,
                                           input logic [31:0] bits);
    logic [7:0] r;
    logic       fb;
    r = 8'hD8;
    for (int i = 0; i < nd; i++) begin
      fb = bits[i] ^ r[0];
      r  = (r >> 1) ^ (fb ? 8'hC4 : 8'h00);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic a, input logic v, input logic d);
    Active    = a;
    Crc_Valid = v;
    Data      = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic send_data(input int nd, input logic [31:0] bits,
                           input bit gaps);
    for (int i = 0; i < nd; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) drive(0, 0, 0);
      drive(1, 0, bits[i]);
    end
  endtask

  task automatic send_crc(input int nc, input logic [7:0] v);
    for (int i = 0; i < nc; i++) drive(0, 1, v[i]);
  endtask

  task automatic verdict(input string tag, input logic p,
                         input logic fe, input logic b);
    chk({tag, ".done"}, 32'(Done), 1);
    chk({tag, ".pass"}, 32'(Pass), 32'(p));
    chk({tag, ".ferr"}, 32'(Frame_Err), 32'(fe));
    chk({tag, ".busy"}, 32'(Busy), 32'(b));
    if (!p && exp_err < 255) exp_err++;
  endtask

  task automatic settle(input string tag);
    drive(0, 0, 0);
    chk({tag, ".done_lo"}, 32'(Done), 0);
    chk({tag, ".errcnt"}, 32'(Err_Count), exp_err);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".busy"}, 32'(Busy), 0);
    chk({tag, ".done"}, 32'(Done), 0);
    chk({tag, ".pass"}, 32'(Pass), 0);
    chk({tag, ".ferr"}, 32'(Frame_Err), 0);
    chk({tag, ".errcnt"}, 32'(Err_Count), 0);
  endtask

  initial begin
    logic [31:0] db;
    logic [7:0]  crc;
    logic [7:0]  sent;
    int          nd;

    n_assert  = 0;
    n_fail    = 0;
    exp_err   = 0;
    Rst       = 1'b1;
    Data      = 1'b0;
    Active    = 1'b0;
    Crc_Valid = 1'b0;
    Clr_Cnt   = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_reset("reset");
    Rst = 1'b0;
    drive(0, 0, 0);

    // Directed all-zero frame, good and bad CRC.
    send_data(8, 32'h0, 0);
    chk("busy_data", 32'(Busy), 1);
    send_crc(8, 8'h14);
    verdict("zero8_good", 1, 0, 0);
    settle("zero8_good");
    send_data(8, 32'h0, 0);
    send_crc(8, 8'h15);
    verdict("zero8_bad", 0, 0, 0);
    settle("zero8_bad");

    // Zero-length frames.
    send_crc(8, 8'hD8);
    verdict("empty_good", 1, 0, 0);
    settle("empty_good");
    send_crc(8, 8'h00);
    verdict("empty_bad", 0, 0, 0);
    settle("empty_bad");

    // Short CRC phase.
    db = $urandom;
    nd = $urandom_range(1, 24);
    send_data(nd, db, 1);
    send_crc(5, model_crc(nd, db));
    chk("short.busy", 32'(Busy), 1);
    chk("short.nodone", 32'(Done), 0);
    drive(0, 0, 0);
    verdict("short", 0, 1, 0);
    settle("short");

    // Restart mid-CRC, then the new frame must pass.
    db = $urandom;
    send_data(10, db, 0);
    send_crc(3, model_crc(10, db));
    db = $urandom;
    nd = 12;
    drive(1, 0, db[0]);
    verdict("restart", 0, 1, 1);
    send_data(1, db >> 1, 0);
    chk("restart.done_lo", 32'(Done), 0);
    chk("restart.errcnt", 32'(Err_Count), exp_err);
    send_data(nd - 2, db >> 2, 1);
    send_crc(8, model_crc(nd, db));
    verdict("restart_next", 1, 0, 0);
    settle("restart_next");

    // Random frames, about half with a single corrupted CRC bit.
    for (int f = 0; f < 24; f++) begin
      nd   = $urandom_range(0, 24);
      db   = $urandom;
      crc  = model_crc(nd, db);
      sent = crc;
      if ($urandom_range(0, 1) == 1) sent[$urandom_range(0, 7)] ^= 1'b1;
      send_data(nd, db, 1);
      send_crc(8, sent);
      verdict("rand", sent == crc, 0, 0);
      settle("rand");
    end

    // Saturation of the failed-frame counter.
    for (int f = 0; f < 258; f++) begin
      send_crc(8, 8'h00);
      if (exp_err < 255) exp_err++;
    end
    drive(0, 0, 0);
    chk("sat.errcnt", 32'(Err_Count), exp_err);
    chk("sat.value", 32'(Err_Count), 255);

    // Clear coinciding with a failing verdict.
    send_crc(7, 8'h00);
    Clr_Cnt = 1'b1;
    drive(0, 1, 0);
    chk("clr.done", 32'(Done), 1);
    chk("clr.pass", 32'(Pass), 0);
    drive(0, 0, 0);
    Clr_Cnt = 1'b0;
    exp_err = 0;
    chk("clr.errcnt", 32'(Err_Count), exp_err);
    send_crc(8, 8'h01);
    verdict("after_clr", 0, 0, 0);
    settle("after_clr");

    // Reset during DATA.
    send_data(5, $urandom, 0);
    #2 Rst = 1'b1;
    #1;
    exp_err = 0;
    check_reset("rst_data");
    @(posedge Clk);
    #1 Rst = 1'b0;
    drive(0, 0, 0);
    chk("rst_data.nodone", 32'(Done), 0);

    // Reset during CHECK, after a failing frame set Pass/Err state.
    send_crc(8, 8'h00);
    db = $urandom;
    send_data(9, db, 0);
    send_crc(4, model_crc(9, db));
    #2 Rst = 1'b1;
    #1;
    exp_err = 0;
    check_reset("rst_check");
    @(posedge Clk);
    #1 Rst = 1'b0;
    drive(0, 0, 0);
    chk("rst_check.nodone", 32'(Done), 0);
    drive(0, 0, 0);
    chk("rst_check.nodone2", 32'(Done), 0);

    db = $urandom;
    send_data(16, db, 1);
    send_crc(8, model_crc(16, db));
    verdict("post_rst", 1, 0, 0);
    settle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
